// File: rtl/trunk_link_allocator_pkg.sv
// Shared LAG router parameters and helpers.
//   LAG_NP / LAG_NL       : default input-port count and max links per trunk
//   link_onehot_t         : one-hot physical-link select within a trunk
//   LAG_route_valid_turn  : whether input port p may route to output trunk t
package trunk_link_allocator_pkg;

  localparam int unsigned LAG_NP = 5;
  localparam int unsigned LAG_NL = 2;

  typedef logic [LAG_NL-1:0] link_onehot_t;

  // Trunk 0 is local ejection and accepts traffic from every input.
  // Input port p arrives on trunk p, so routing it back to trunk p is a U-turn.
  function automatic logic LAG_route_valid_turn(input int unsigned port,
                                                input int unsigned trunk);
    return (trunk == 0) || (port != trunk);
  endfunction

endpackage

// File: rtl/trunk_link_allocator_rr_arbiter.sv
// N-way round-robin arbiter with a registered priority pointer.
//   clk, rst_n  : clock, async active-low reset (pointer -> 0)
//   req_i       : per-requester request
//   advance_i   : the current winner is consumed; pointer moves past it
//   grant_o     : one-hot winner, first requester at or after the pointer
module trunk_link_allocator_rr_arbiter #(
  parameter int unsigned N = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_i,
  input  logic         advance_i,
  output logic [N-1:0] grant_o
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;

  always_comb begin
    int unsigned idx;
    int unsigned nxt;
    logic        found;
    logic [PW-1:0] sel;
    grant_o = '0;
    ptr_d   = ptr_q;
    idx     = 0;
    nxt     = 0;
    found   = 1'b0;
    sel     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= N) idx = idx - N;
      sel = PW'(idx);
      if (!found && req_i[sel]) begin
        found        = 1'b1;
        grant_o[sel] = 1'b1;
        nxt          = (idx + 1 == N) ? 0 : idx + 1;
      end
    end
    if (advance_i && found) ptr_d = PW'(nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/trunk_link_allocator.sv
// Per-output-trunk link allocator: grants one free, unblocked physical link of
// this trunk to a requesting input port and holds it until the port's tail flit.
//   clk, rst_n      : clock, async active-low reset (frees every link)
//   req_i[NP]       : port requests a link (level, held until granted)
//   release_i[NP]   : port sent its tail flit on its owned link this cycle
//   link_blocked_i  : downstream flow control per link
//   grant_o[NP]     : one-cycle pulse, port was just allocated a link
//   alloc_valid_o   : port currently owns a link
//   alloc_link_o    : one-hot owned link per port, bits [p*NL +: NL]
//   link_busy_o     : link currently owned by some port
//   port_blocked_o  : port owns a link that is currently blocked (combinational)
module trunk_link_allocator
  import trunk_link_allocator_pkg::*;
#(
  parameter int unsigned NP           = LAG_NP,
  parameter int unsigned NL           = LAG_NL,
  parameter int unsigned NUM_LINKS    = 2,
  parameter int unsigned OUTPUT_TRUNK = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NP-1:0]    req_i,
  input  logic [NP-1:0]    release_i,
  input  logic [NL-1:0]    link_blocked_i,
  output logic [NP-1:0]    grant_o,
  output logic [NP-1:0]    alloc_valid_o,
  output logic [NP*NL-1:0] alloc_link_o,
  output logic [NL-1:0]    link_busy_o,
  output logic [NP-1:0]    port_blocked_o
);

  logic [NP-1:0]    grant_q, grant_d;
  logic [NP-1:0]    alloc_valid_q, alloc_valid_d;
  logic [NP*NL-1:0] own_q, own_d;
  logic [NL-1:0]    link_busy_q, link_busy_d;

  logic [NP-1:0] turn_ok, eligible, winner;
  logic [NL-1:0] present, cand, pick;
  logic          any_cand;

  always_comb begin
    for (int unsigned p = 0; p < NP; p++) turn_ok[p] = LAG_route_valid_turn(p, OUTPUT_TRUNK);
    for (int unsigned l = 0; l < NL; l++) present[l] = (l < NUM_LINKS);
  end

  // A port releasing this cycle is still an owner, so it is never eligible.
  assign eligible = req_i & ~alloc_valid_q & ~release_i & turn_ok;
  assign cand     = present & ~link_busy_q & ~link_blocked_i;
  // Isolate the lowest set bit: lowest-index free link wins.
  assign pick     = cand & (~cand + NL'(1));
  assign any_cand = |cand;

  trunk_link_allocator_rr_arbiter #(.N(NP)) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (eligible),
    .advance_i (any_cand),
    .grant_o   (winner)
  );

  always_comb begin
    grant_d     = any_cand ? winner : '0;
    own_d       = own_q;
    link_busy_d = '0;
    for (int unsigned p = 0; p < NP; p++) begin
      if (release_i[p] && alloc_valid_q[p]) own_d[p*NL +: NL] = '0;
      if (grant_d[p])                       own_d[p*NL +: NL] = pick;
      alloc_valid_d[p] = |own_d[p*NL +: NL];
      link_busy_d      = link_busy_d | own_d[p*NL +: NL];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q       <= '0;
      alloc_valid_q <= '0;
      own_q         <= '0;
      link_busy_q   <= '0;
    end else begin
      grant_q       <= grant_d;
      alloc_valid_q <= alloc_valid_d;
      own_q         <= own_d;
      link_busy_q   <= link_busy_d;
    end
  end

  always_comb begin
    for (int unsigned p = 0; p < NP; p++)
      port_blocked_o[p] = alloc_valid_q[p] & |(own_q[p*NL +: NL] & link_blocked_i);
  end

  assign grant_o       = grant_q;
  assign alloc_valid_o = alloc_valid_q;
  assign alloc_link_o  = own_q;
  assign link_busy_o   = link_busy_q;

endmodule

// File: tb/tb_trunk_link_allocator.sv
module tb_trunk_link_allocator;

  typedef struct {
    int         port;
    logic [1:0] link;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DUT A: NUM_LINKS=2, OUTPUT_TRUNK=0
  logic [4:0] req_a, rel_a, grant_a, av_a, pb_a;
  logic [1:0] blk_a, busy_a;
  logic [9:0] link_a;
  // DUT B: NUM_LINKS=1, OUTPUT_TRUNK=2 (port 2 is a forbidden turn)
  logic [4:0] req_b, rel_b, grant_b, av_b, pb_b;
  logic [1:0] blk_b, busy_b;
  logic [9:0] link_b;

  trunk_link_allocator #(.NP(5), .NL(2), .NUM_LINKS(2), .OUTPUT_TRUNK(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_i(req_a), .release_i(rel_a), .link_blocked_i(blk_a),
    .grant_o(grant_a), .alloc_valid_o(av_a), .alloc_link_o(link_a),
    .link_busy_o(busy_a), .port_blocked_o(pb_a));

  trunk_link_allocator #(.NP(5), .NL(2), .NUM_LINKS(1), .OUTPUT_TRUNK(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_i(req_b), .release_i(rel_b), .link_blocked_i(blk_b),
    .grant_o(grant_b), .alloc_valid_o(av_b), .alloc_link_o(link_b),
    .link_busy_o(busy_b), .port_blocked_o(pb_b));

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitors: every grant pops the next expected allocation.
  always @(negedge clk) begin
    if (rst_n && grant_a != 5'b0) begin
      if (qa.size() == 0) chk("A unexpected grant", 32'(grant_a), 32'h0);
      else begin
        ea = qa.pop_front();
        chk("A grant port", 32'(grant_a), 32'(1) << ea.port);
        chk("A grant link", 32'(link_a[ea.port*2 +: 2]), 32'(ea.link));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && grant_b != 5'b0) begin
      if (qb.size() == 0) chk("B unexpected grant", 32'(grant_b), 32'h0);
      else begin
        eb = qb.pop_front();
        chk("B grant port", 32'(grant_b), 32'(1) << eb.port);
        chk("B grant link", 32'(link_b[eb.port*2 +: 2]), 32'(eb.link));
      end
    end
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1);
  end

  initial begin
    int cnt [5];
    int ngr;
    rst_n = 1'b0;
    req_a = '0; rel_a = '0; blk_a = '0;
    req_b = '0; rel_b = '0; blk_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset grant", 32'(grant_a), 0);
    chk("reset alloc_valid", 32'(av_a), 0);
    chk("reset alloc_link", 32'(link_a), 0);
    chk("reset link_busy", 32'(busy_a), 0);
    rst_n = 1'b1;
    tick;

    // Two requesters: port 1 then port 2, lowest free link first.
    req_a = 5'b00110;
    qa.push_back(exp_t'{1, 2'b01});
    qa.push_back(exp_t'{2, 2'b10});
    tick;
    req_a = 5'b00100;
    tick;
    req_a = 5'b01000;
    chk("both links busy", 32'(busy_a), 32'h3);
    chk("alloc_valid 1,2", 32'(av_a), 32'h06);

    // Port 3 waits while both links are owned; release of port 1 frees link 0.
    repeat (2) tick;
    chk("port3 starved of links", 32'(av_a[3]), 0);
    qa.push_back(exp_t'{3, 2'b01});
    rel_a = 5'b00010;
    tick;
    rel_a = '0;
    chk("link_busy after release", 32'(busy_a), 32'h2);
    chk("no grant at release+1", 32'(grant_a), 0);
    tick;
    chk("grant at release+2", 32'(grant_a), 32'h08);
    req_a = '0;
    chk("alloc_link map", 32'(link_a), 32'h060);
    tick;

    // Asynchronous reset in the middle of a cycle with links owned.
    #2 rst_n = 1'b0;
    #1;
    chk("async reset grant", 32'(grant_a), 0);
    chk("async reset alloc_valid", 32'(av_a), 0);
    chk("async reset alloc_link", 32'(link_a), 0);
    chk("async reset link_busy", 32'(busy_a), 0);
    chk("async reset port_blocked", 32'(pb_a), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick;

    // Blocked link 0 is skipped; later blocking of the owned link is reported.
    blk_a = 2'b01;
    req_a = 5'b10000;
    qa.push_back(exp_t'{4, 2'b10});
    tick;
    req_a = '0;
    chk("port4 took link1", 32'(link_a[9:8]), 32'h2);
    chk("port4 not blocked", 32'(pb_a), 0);
    blk_a = 2'b10;
    #1;
    chk("port4 blocked same cycle", 32'(pb_a), 32'h10);
    tick;
    chk("blocked alloc kept valid", 32'(av_a), 32'h10);
    chk("blocked alloc kept link", 32'(link_a[9:8]), 32'h2);
    blk_a = '0;
    rel_a = 5'b10000;
    tick;
    rel_a = '0;
    chk("port4 released", 32'(av_a), 0);
    chk("links free", 32'(busy_a), 0);

    // DUT B: forbidden turn is never granted; single-link trunk never uses link 1.
    req_b = 5'b00100;
    repeat (10) begin
      tick;
      chk("B port2 forbidden", 32'(av_b[2]), 0);
    end
    req_b = 5'b00110;
    qb.push_back(exp_t'{1, 2'b01});
    repeat (10) begin
      tick;
      chk("B port2 forbidden", 32'(av_b[2]), 0);
      chk("B link1 absent", 32'(busy_b[1]), 0);
    end
    chk("B only port1 owns", 32'(av_b), 32'h02);
    req_b = '0;
    rel_b = 5'b00010;
    tick;
    rel_b = '0;
    chk("B link freed", 32'(busy_b), 0);

    // Fairness: prime the pointer to 1 with a grant to port 0, then all request.
    req_a = 5'b00001;
    qa.push_back(exp_t'{0, 2'b01});
    tick;
    req_a = '0;
    rel_a = 5'b00001;
    tick;
    rel_a = '0;
    tick;
    for (int k = 0; k < 10; k++)
      qa.push_back(exp_t'{(1 + k) % 5, (k % 2 == 0) ? 2'b01 : 2'b10});
    for (int p = 0; p < 5; p++) cnt[p] = 0;
    ngr = 0;
    req_a = 5'b11111;
    for (int cyc = 0; cyc < 120 && (ngr < 10 || av_a != 5'b0); cyc++) begin
      tick;
      rel_a = '0;
      for (int p = 0; p < 5; p++)
        if (cnt[p] > 0) begin
          cnt[p]--;
          if (cnt[p] == 0) rel_a[p] = 1'b1;
        end
      for (int p = 0; p < 5; p++)
        if (grant_a[p]) begin
          cnt[p] = 3;
          ngr++;
        end
      if (ngr >= 10) req_a = '0;
    end
    rel_a = '0;
    chk("fairness grant count", 32'(ngr), 10);
    chk("fairness all released", 32'(av_a), 0);

    repeat (3) tick;
    chk("A scoreboard drained", 32'(qa.size()), 0);
    chk("B scoreboard drained", 32'(qb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
